// File: rtl/axis_stub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_stub_pkg : shared types and beat-sizing helpers for axis_stub_pkt_gen   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package axis_stub_pkg;

   localparam int unsigned MAX_KEEP_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef logic [MAX_KEEP_W-1:0] keep_max_t;

   // A zero remainder means the last beat is completely full.
   function automatic keep_max_t keep_from_rem(input int unsigned rem, input int unsigned bytes);
      keep_max_t k;
      k = '0;
      for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
         if ((rem == 0 && i < bytes) || (i < rem)) begin
            k[i[5:0]] = 1'b1;
         end
      end
      return k;
   endfunction

   function automatic int unsigned beats_from_len(input int unsigned len, input int unsigned bytes);
      return (len + bytes - 1) / bytes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_stub_beat_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_stub_beat_ctr : beat-in-packet counter producing registered tlast/tkeep |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module axis_stub_beat_ctr
   import axis_stub_pkg::*;
#(
   parameter int C_TDATA_WIDTH = 32,
   parameter int C_LEN_WIDTH   = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       load,
   input  logic [C_LEN_WIDTH-1:0]     len,
   input  logic                       advance,
   output logic                       tlast,
   output logic [C_TDATA_WIDTH/8-1:0] tkeep
);

   localparam int KEEP_W = C_TDATA_WIDTH / 8;
   localparam int unsigned BYTES = C_TDATA_WIDTH / 8;

   logic [C_LEN_WIDTH-1:0] beats_q, beats_d;
   logic [C_LEN_WIDTH-1:0] beat_q, beat_d;
   logic [KEEP_W-1:0]      last_keep_q, last_keep_d;
   logic [KEEP_W-1:0]      keep_q, keep_d;
   logic                   last_q, last_d;

   logic [31:0]            len_eff;
   logic [C_LEN_WIDTH-1:0] load_beats;
   keep_max_t              keep_max;
   logic [KEEP_W-1:0]      load_last_keep;

   // A zero length is treated as a one-byte packet.
   assign len_eff    = (len == '0) ? 32'd1 : 32'(len);
   assign load_beats = C_LEN_WIDTH'(beats_from_len(len_eff, BYTES));
   assign keep_max   = keep_from_rem(len_eff % BYTES, BYTES);

   generate
      if (KEEP_W == MAX_KEEP_W) begin : g_keep_full
         assign load_last_keep = keep_max;
      end else begin : g_keep_slice
         logic unused_keep_bits;
         assign load_last_keep   = keep_max[KEEP_W-1:0];
         assign unused_keep_bits = |keep_max[MAX_KEEP_W-1:KEEP_W];
      end
   endgenerate

   always_comb begin
      beats_d     = beats_q;
      beat_d      = beat_q;
      last_keep_d = last_keep_q;
      keep_d      = keep_q;
      last_d      = last_q;
      if (load) begin
         beats_d     = load_beats;
         last_keep_d = load_last_keep;
         beat_d      = '0;
         last_d      = (load_beats == C_LEN_WIDTH'(1));
         keep_d      = last_d ? load_last_keep : '1;
      end else if (advance) begin
         if (last_q) begin
            beat_d = '0;
            last_d = (beats_q == C_LEN_WIDTH'(1));
         end else begin
            beat_d = beat_q + C_LEN_WIDTH'(1);
            last_d = (beat_d == beats_q - C_LEN_WIDTH'(1));
         end
         keep_d = last_d ? last_keep_q : '1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beats_q     <= '0;
         beat_q      <= '0;
         last_keep_q <= '0;
         keep_q      <= '0;
         last_q      <= 1'b0;
      end else begin
         beats_q     <= beats_d;
         beat_q      <= beat_d;
         last_keep_q <= last_keep_d;
         keep_q      <= keep_d;
         last_q      <= last_d;
      end
   end

   assign tlast = last_q;
   assign tkeep = keep_q;

endmodule
`default_nettype wire

// File: rtl/axis_stub_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_stub_pkt_gen : AXI4-Stream counting-payload packet generator            |
// | Option macro AXIS_STUB_PKT_GEN_TUSER_SOP_EN drives m_tuser[0] as SOP.        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module axis_stub_pkt_gen
   import axis_stub_pkg::*;
#(
   parameter int C_TDATA_WIDTH = 32,
   parameter int C_TID_WIDTH   = 1,
   parameter int C_TDEST_WIDTH = 1,
   parameter int C_TUSER_WIDTH = 1,
   parameter int C_LEN_WIDTH   = 16,
   parameter int C_CNT_WIDTH   = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       start,
   input  logic [C_LEN_WIDTH-1:0]     cfg_len_bytes,
   input  logic [C_CNT_WIDTH-1:0]     cfg_num_pkts,
   input  logic [C_CNT_WIDTH-1:0]     cfg_gap,
   input  logic [C_TID_WIDTH-1:0]     cfg_tid,
   input  logic [C_TDEST_WIDTH-1:0]   cfg_tdest,
   input  logic [C_TDATA_WIDTH-1:0]   cfg_seed,
   output logic                       busy,
   output logic                       done,
   output logic [C_CNT_WIDTH-1:0]     pkt_count,
   output logic [C_TDATA_WIDTH-1:0]   m_tdata,
   output logic [C_TDATA_WIDTH/8-1:0] m_tkeep,
   output logic [C_TDATA_WIDTH/8-1:0] m_tstrb,
   output logic                       m_tlast,
   output logic [C_TID_WIDTH-1:0]     m_tid,
   output logic [C_TDEST_WIDTH-1:0]   m_tdest,
   output logic [C_TUSER_WIDTH-1:0]   m_tuser,
   output logic                       m_tvalid,
   input  logic                       m_tready
);

   localparam int KEEP_W = C_TDATA_WIDTH / 8;

   state_t                   state_q, state_d;
   logic [C_CNT_WIDTH-1:0]   num_q, num_d;
   logic [C_CNT_WIDTH-1:0]   gap_q, gap_d;
   logic [C_CNT_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
   logic [C_CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;
   logic [C_TID_WIDTH-1:0]   tid_q, tid_d;
   logic [C_TDEST_WIDTH-1:0] tdest_q, tdest_d;
   logic [C_TDATA_WIDTH-1:0] data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic                     load;
   logic                     hs;
   logic                     beat_last;
   logic [KEEP_W-1:0]        beat_keep;

   assign load = (state_q == IDLE) && start;
   assign hs   = valid_q && m_tready;

   axis_stub_beat_ctr #(
      .C_TDATA_WIDTH (C_TDATA_WIDTH),
      .C_LEN_WIDTH   (C_LEN_WIDTH)
   ) u_beat_ctr (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (load),
      .len     (cfg_len_bytes),
      .advance (hs),
      .tlast   (beat_last),
      .tkeep   (beat_keep)
   );

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      pkt_count_d = pkt_count_q;
      tid_d       = tid_q;
      tdest_d     = tdest_q;
      data_d      = data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               num_d       = cfg_num_pkts;
               gap_d       = cfg_gap;
               tid_d       = cfg_tid;
               tdest_d     = cfg_tdest;
               data_d      = cfg_seed;
               pkt_count_d = '0;
               state_d     = (cfg_num_pkts == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (hs) begin
               data_d = data_q + C_TDATA_WIDTH'(1);
               if (beat_last) begin
                  pkt_count_d = pkt_count_q + C_CNT_WIDTH'(1);
                  if (pkt_count_d == num_q) begin
                     state_d = DONE;
                  end else if (gap_q != '0) begin
                     gap_cnt_d = gap_q - C_CNT_WIDTH'(1);
                     state_d   = GAP;
                  end
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = SEND;
            end else begin
               gap_cnt_d = gap_cnt_q - C_CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs are registered decodes of the state they describe.
   assign valid_d = (state_d == SEND);
   assign busy_d  = (state_d == SEND) || (state_d == GAP);
   assign done_d  = (state_q == DONE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         num_q       <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         pkt_count_q <= '0;
         tid_q       <= '0;
         tdest_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         pkt_count_q <= pkt_count_d;
         tid_q       <= tid_d;
         tdest_q     <= tdest_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef AXIS_STUB_PKT_GEN_TUSER_SOP_EN
   logic sop_q, sop_d;

   // The beat after a last beat is the first beat of the next packet.
   always_comb begin
      sop_d = sop_q;
      if (load) begin
         sop_d = 1'b1;
      end else if (hs) begin
         sop_d = beat_last;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sop_q <= 1'b0;
      end else begin
         sop_q <= sop_d;
      end
   end

   assign m_tuser = C_TUSER_WIDTH'(sop_q);
`else
   assign m_tuser = '0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign pkt_count = pkt_count_q;
   assign m_tdata   = data_q;
   assign m_tkeep   = beat_keep;
   assign m_tstrb   = beat_keep;
   assign m_tlast   = beat_last;
   assign m_tid     = tid_q;
   assign m_tdest   = tdest_q;
   assign m_tvalid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_stub_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axis_stub_pkt_gen : self-checking bench for axis_stub_pkt_gen             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_axis_stub_pkt_gen;

   localparam int W     = 32;
   localparam int BYTES = W / 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   cfg_len_bytes = '0;
   logic [15:0]   cfg_num_pkts = '0;
   logic [15:0]   cfg_gap = '0;
   logic [0:0]    cfg_tid = '0;
   logic [0:0]    cfg_tdest = '0;
   logic [W-1:0]  cfg_seed = '0;
   logic          busy, done;
   logic [15:0]   pkt_count;
   logic [W-1:0]  m_tdata;
   logic [3:0]    m_tkeep, m_tstrb;
   logic          m_tlast;
   logic [0:0]    m_tid, m_tdest, m_tuser;
   logic          m_tvalid;
   logic          m_tready = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] data;
      logic [3:0]   keep;
      logic         last;
      logic         sop;
   } beat_t;

   beat_t exp_q[$];

   axis_stub_pkt_gen dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .start         (start),
      .cfg_len_bytes (cfg_len_bytes),
      .cfg_num_pkts  (cfg_num_pkts),
      .cfg_gap       (cfg_gap),
      .cfg_tid       (cfg_tid),
      .cfg_tdest     (cfg_tdest),
      .cfg_seed      (cfg_seed),
      .busy          (busy),
      .done          (done),
      .pkt_count     (pkt_count),
      .m_tdata       (m_tdata),
      .m_tkeep       (m_tkeep),
      .m_tstrb       (m_tstrb),
      .m_tlast       (m_tlast),
      .m_tid         (m_tid),
      .m_tdest       (m_tdest),
      .m_tuser       (m_tuser),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready)
   );

   always #5 aclk = ~aclk;

   // Runs one configuration; cycle 0 is the cycle start is presented in.
   // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
   task automatic run_pkt(input string name, input int len, input int num, input int gap,
                          input logic [W-1:0] seed, input int rmode);
      int         l_eff, nb, rem, idx, cyc, last_hs, gap_cnt, err0;
      logic       in_gap, finished, exp_tuser;
      logic [3:0] lkeep;
      logic [0:0] tid, tdest;
      beat_t      b;
      exp_q.delete();
      l_eff = (len == 0) ? 1 : len;
      nb    = (l_eff + BYTES - 1) / BYTES;
      rem   = l_eff % BYTES;
      lkeep = (rem == 0) ? 4'hF : 4'((1 << rem) - 1);
      idx   = 0;
      for (int p = 0; p < num; p++) begin
         for (int k = 0; k < nb; k++) begin
            b.data = seed + W'(idx);
            b.last = (k == nb - 1);
            b.keep = b.last ? lkeep : 4'hF;
            b.sop  = (k == 0);
            exp_q.push_back(b);
            idx++;
         end
      end
      tid   = 1'($urandom);
      tdest = 1'($urandom);
      @(negedge aclk);
      cfg_len_bytes = 16'(len);
      cfg_num_pkts  = 16'(num);
      cfg_gap       = 16'(gap);
      cfg_tid       = tid;
      cfg_tdest     = tdest;
      cfg_seed      = seed;
      start         = 1'b1;
      cyc      = 0;
      last_hs  = 0;
      gap_cnt  = 0;
      in_gap   = 1'b0;
      finished = (num == 0);
      err0     = errors;
      while (cyc < 3000 && !(finished && cyc > last_hs + 3) && errors < err0 + 20) begin
         @(negedge aclk);
         cyc++;
         // Configuration churn and stray starts during the run must be ignored.
         start         = busy && ($urandom_range(0, 7) == 0);
         cfg_len_bytes = 16'($urandom);
         cfg_num_pkts  = 16'($urandom);
         cfg_gap       = 16'($urandom);
         cfg_tid       = 1'($urandom);
         cfg_tdest     = 1'($urandom);
         cfg_seed      = $urandom;
         if (rmode == 0) m_tready = 1'b1;
         else if (rmode == 1) m_tready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
         else m_tready = 1'($urandom_range(0, 1));

         checks++;
         if (busy !== ((num > 0) && !finished)) begin
            errors++;
            $display("FAIL %s busy cyc=%0d: got %b exp %b", name, cyc, busy, (num > 0) && !finished);
         end
         checks++;
         if (done !== (finished && cyc == last_hs + 2)) begin
            errors++;
            $display("FAIL %s done cyc=%0d: got %b exp %b", name, cyc, done, finished && cyc == last_hs + 2);
         end

         if (finished) begin
            checks++;
            if (m_tvalid !== 1'b0) begin
               errors++;
               $display("FAIL %s tvalid_after_run cyc=%0d: got %b exp 0", name, cyc, m_tvalid);
            end
         end else begin
            if (in_gap) begin
               if (m_tvalid !== 1'b1) gap_cnt++;
               else begin
                  checks++;
                  if (gap_cnt != gap) begin
                     errors++;
                     $display("FAIL %s gap_len: got %0d exp %0d", name, gap_cnt, gap);
                  end
                  in_gap = 1'b0;
               end
            end
            if (!in_gap) begin
               checks++;
               if (m_tvalid !== 1'b1) begin
                  errors++;
                  $display("FAIL %s tvalid_drop cyc=%0d: got %b exp 1", name, cyc, m_tvalid);
               end else begin
                  b = exp_q[0];
`ifdef AXIS_STUB_PKT_GEN_TUSER_SOP_EN
                  exp_tuser = b.sop;
`else
                  exp_tuser = 1'b0;
`endif
                  checks++;
                  if (m_tdata !== b.data || m_tkeep !== b.keep || m_tstrb !== b.keep ||
                      m_tlast !== b.last || m_tid !== tid || m_tdest !== tdest || m_tuser !== exp_tuser) begin
                     errors++;
                     $display("FAIL %s beat cyc=%0d: got d=%h k=%h s=%h l=%b id=%b de=%b u=%b exp d=%h k=%h l=%b id=%b de=%b u=%b",
                              name, cyc, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser,
                              b.data, b.keep, b.last, tid, tdest, exp_tuser);
                  end
                  if (m_tready) begin
                     void'(exp_q.pop_front());
                     if (exp_q.size() == 0) begin
                        finished = 1'b1;
                        last_hs  = cyc;
                     end else if (b.last && gap > 0) begin
                        in_gap  = 1'b1;
                        gap_cnt = 0;
                     end
                  end
               end
            end
         end
      end
      start = 1'b0;
      checks++;
      if (!finished || cyc <= last_hs + 3) begin
         errors++;
         $display("FAIL %s completion: got %0d beats left exp 0", name, exp_q.size());
      end
      checks++;
      if (pkt_count !== 16'(num)) begin
         errors++;
         $display("FAIL %s pkt_count: got %0d exp %0d", name, pkt_count, num);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({busy, done, pkt_count, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser, m_tvalid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d d=%h k=%h v=%b exp all 0",
                  busy, done, pkt_count, m_tdata, m_tkeep, m_tvalid);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (2) @(negedge aclk);
   endtask

   task automatic test_basic();
      run_pkt("basic", 10, 2, 0, 32'h100, 0);
   endtask

   task automatic test_backpressure();
      run_pkt("backpressure", 10, 2, 0, 32'h100, 1);
   endtask

   task automatic test_gap();
      run_pkt("gap", 4, 3, 2, 32'h5000, 0);
      run_pkt("gap_bp", 7, 3, 3, 32'h77, 2);
   endtask

   task automatic test_zero_pkts();
      run_pkt("zero_pkts", 10, 0, 1, 32'h1, 0);
   endtask

   task automatic test_boundaries();
      run_pkt("len_zero", 0, 2, 0, 32'hABC, 0);
      run_pkt("len_full", 8, 2, 1, 32'h10, 0);
      run_pkt("wrap", 16, 1, 0, 32'hFFFF_FFFE, 0);
   endtask

   task automatic test_reset_mid_packet();
      @(negedge aclk);
      cfg_len_bytes = 16'd12;
      cfg_num_pkts  = 16'd1;
      cfg_gap       = 16'd0;
      cfg_tid       = 1'b1;
      cfg_tdest     = 1'b1;
      cfg_seed      = 32'h200;
      start         = 1'b1;
      m_tready      = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      @(negedge aclk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h201) begin
         errors++;
         $display("FAIL rst_mid_beat2: got v=%b d=%h exp v=1 d=00000201", m_tvalid, m_tdata);
      end
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if ({busy, done, pkt_count, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser, m_tvalid} !== '0) begin
         errors++;
         $display("FAIL rst_mid_async: got busy=%b cnt=%0d d=%h k=%h id=%b v=%b exp all 0",
                  busy, pkt_count, m_tdata, m_tkeep, m_tid, m_tvalid);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         checks++;
         if (m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_idle: got v=%b busy=%b done=%b cnt=%0d exp 0 0 0 0",
                     m_tvalid, busy, done, pkt_count);
         end
      end
      run_pkt("post_reset", 12, 2, 1, 32'h300, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         run_pkt("random", $urandom_range(0, 24), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom, 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gap();
      test_zero_pkts();
      test_boundaries();
      test_reset_mid_packet();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
